// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: packet-sequencing FSM for the 1x3 router (header decode, byte-load sequencing, stalls).
// Define ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN to abort a WAIT_TILL_EMPTY that outlasts WAIT_TIMEOUT cycles.
module router_pkt_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned TMO_W        = 7
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       wait_timeout
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] empty_vec, srst_vec;
  logic       tgt_empty, tgt_srst, timeout_hit;

  // Port 3 does not exist: its slot reads as "not empty" and "no soft reset".
  assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srst_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign tgt_empty = empty_vec[(state_q == DECODE_ADDRESS) ? data_in : addr_q];
  assign tgt_srst  = srst_vec[addr_q];

`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             wait_timeout_q, wait_timeout_d;

  assign timeout_hit = (state_q == WAIT_TILL_EMPTY) && !tgt_empty &&
                       (tmo_q == TMO_W'(WAIT_TIMEOUT - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{WAIT_TIMEOUT[0], TMO_W[0]};
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = data_in;

    if (state_q != DECODE_ADDRESS && tgt_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != 2'd3)
            state_d = tgt_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (tgt_empty)        state_d = LOAD_FIRST_DATA;
          else if (timeout_hit) state_d = DECODE_ADDRESS;
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // NOTE: reset here is synchronous, so it is sampled only on the clock edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ROUTER_PKT_CTRL_WAIT_TIMEOUT_EN
  // Counter is zero outside the wait, so it starts from zero on every entry.
  always_comb begin
    tmo_d          = '0;
    wait_timeout_d = timeout_hit && !tgt_srst;
    if (state_q == WAIT_TILL_EMPTY && state_d == WAIT_TILL_EMPTY)
      tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tmo_q          <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      tmo_q          <= tmo_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  assign wait_timeout = wait_timeout_q;
`else
  assign wait_timeout = 1'b0;
`endif

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule
